// File: rtl/edu_arb.sv
// Round-robin arbiter letting N_REQ requesters share one Hamming(7,4) EDU,
// with a response timeout and per-requester corrected-error counters.
module edu_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [7*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [6:0]         rsp_data,
  output logic               rsp_corrected,
  output logic               rsp_timeout,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic               edu_in_valid,
  output logic [6:0]         edu_in_data,
  input  logic               edu_in_ready,
  input  logic               edu_out_valid,
  input  logic [6:0]         edu_out_data,
  output logic               edu_out_ready,
  output logic [IDW-1:0]     grant_id,
  output logic [8*N_REQ-1:0] err_count
);

  localparam int unsigned   TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, grant_id_q, pick_idx;
  logic           pick_valid;
  logic [TW-1:0]  timer_q;
  logic [6:0]     raw_q, res_q;
  logic           corr_q, tout_q;
  logic [7:0]     err_q [N_REQ];
  logic [6:0]     req_cw [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign req_cw[i]             = req_data[7*i +: 7];
    assign err_count[8*i +: 8]   = err_q[i];
  end

  assign grant_id = grant_id_q;
  // Stale EDU beats are always drained, except while held in reset.
  assign edu_out_ready = ~rst;

  // First valid requester at or after rr_ptr, wrapping upward.
  always_comb begin
    logic [IDW-1:0] cand;
    cand       = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = IDW'((32'(rr_ptr_q) + off) % N_REQ);
      if (!pick_valid && req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_valid) state_d = StIssue;
      StIssue:   if (edu_in_ready) state_d = StWait;
      StWait:    if (edu_out_valid || timer_q == TimerLast) state_d = StDeliver;
      StDeliver: if (rsp_ready[grant_id_q]) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_data      = '0;
    rsp_corrected = 1'b0;
    rsp_timeout   = 1'b0;
    edu_in_valid  = 1'b0;
    edu_in_data   = '0;
    unique case (state_q)
      StIdle: if (pick_valid && !rst) req_ready[pick_idx] = 1'b1;
      StIssue: begin
        edu_in_valid = 1'b1;
        edu_in_data  = raw_q;
      end
      StWait: ;
      StDeliver: begin
        rsp_valid[grant_id_q] = 1'b1;
        rsp_data              = res_q;
        rsp_corrected         = corr_q;
        rsp_timeout           = tout_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      timer_q    <= '0;
      raw_q      <= '0;
      res_q      <= '0;
      corr_q     <= 1'b0;
      tout_q     <= 1'b0;
      for (int i = 0; i < N_REQ; i++) err_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            raw_q      <= req_cw[pick_idx];
            grant_id_q <= pick_idx;
          end
        end
        StIssue: if (edu_in_ready) timer_q <= '0;
        StWait: begin
          if (edu_out_valid) begin
            res_q  <= edu_out_data;
            corr_q <= (edu_out_data != raw_q);
            tout_q <= 1'b0;
          end else if (timer_q == TimerLast) begin
            res_q  <= raw_q;
            corr_q <= 1'b0;
            tout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StDeliver: begin
          if (rsp_ready[grant_id_q]) begin
            rr_ptr_q <= IDW'((32'(grant_id_q) + 32'd1) % N_REQ);
            if (corr_q && err_q[grant_id_q] != 8'hff) begin
              err_q[grant_id_q] <= err_q[grant_id_q] + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edu_arb.sv
// Self-checking bench for edu_arb: behavioural Hamming EDU, scoreboard of
// expected responses, and per-feature scenario tasks.
module tb_edu_arb;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk, rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7*N-1:0] req_data;
  logic [6:0]     rsp_data, edu_in_data, edu_out_data;
  logic           rsp_corrected, rsp_timeout;
  logic           edu_in_valid, edu_in_ready, edu_out_valid, edu_out_ready;
  logic [1:0]     grant_id;
  logic [8*N-1:0] err_count;

  edu_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_corrected(rsp_corrected),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready),
    .edu_in_valid(edu_in_valid), .edu_in_data(edu_in_data), .edu_in_ready(edu_in_ready),
    .edu_out_valid(edu_out_valid), .edu_out_data(edu_out_data),
    .edu_out_ready(edu_out_ready),
    .grant_id(grant_id), .err_count(err_count)
  );

  typedef struct {
    int         id;
    logic [6:0] data;
    logic       corr;
    logic       tout;
  } exp_t;

  exp_t       sb[$];
  int         exp_err[N];
  int         errors = 0;
  int         checks = 0;
  bit         edu_on = 1'b1;
  bit         inject = 1'b0;
  bit         pend   = 1'b0;
  logic [6:0] inject_data = '0;
  logic [6:0] pend_data   = '0;

  function automatic logic [6:0] hfix(input logic [6:0] c);
    int         s;
    logic [6:0] r;
    s = 0;
    r = c;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
    if (s != 0) r[s-1] = ~r[s-1];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // EDU model: one-cycle decoder; can be muted (edu_on) or forced to emit a beat (inject).
  initial begin
    edu_out_valid = 1'b0;
    edu_out_data  = '0;
    forever begin
      @(negedge clk);
      edu_out_valid = 1'b0;
      if (inject) begin
        edu_out_valid = 1'b1;
        edu_out_data  = inject_data;
        inject        = 1'b0;
      end else if (pend && edu_on) begin
        edu_out_valid = 1'b1;
        edu_out_data  = pend_data;
      end
      pend = 1'b0;
      if (edu_in_valid && edu_in_ready) begin
        pend      = 1'b1;
        pend_data = hfix(edu_in_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    step();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) exp_err[i] = 0;
    #1;
  endtask

  // One request/response transaction; keep=1 leaves req_valid/req_data to the caller.
  task automatic txn(input int id, input logic [6:0] cw, input bit resp, input int exp_lat,
                     input bit late, input bit keep);
    exp_t       e;
    int         n;
    logic [6:0] fx;
    edu_on = resp;
    if (!keep) begin
      req_valid[id]      = 1'b1;
      req_data[7*id +: 7] = cw;
    end
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== (N'(1) << id)) begin
      errors++;
      $display("FAIL accept id=%0d: req_ready=%b required %b", id, req_ready, N'(1) << id);
      if (!keep) req_valid[id] = 1'b0;
      return;
    end
    fx     = resp ? hfix(cw) : cw;
    e.id   = id;
    e.data = fx;
    e.corr = resp && (fx != cw);
    e.tout = !resp;
    sb.push_back(e);
    step();
    if (!keep) req_valid[id] = 1'b0;
    n = 1;
    while (rsp_valid == '0 && n < 100) begin
      checks++;
      if ({rsp_data, rsp_corrected, rsp_timeout} !== 9'd0) begin
        errors++;
        $display("FAIL idle_rsp_zero: rsp_data=%b corr=%b tout=%b required 0", rsp_data,
                 rsp_corrected, rsp_timeout);
      end
      step();
      n++;
    end
    checks++;
    if (rsp_valid == '0) begin
      errors++;
      $display("FAIL rsp_wait id=%0d: no rsp_valid within %0d cycles", id, n);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (N'(1) << e.id)) begin
      errors++;
      $display("FAIL rsp_valid: got %b required %b", rsp_valid, N'(1) << e.id);
    end
    checks++;
    if (int'(grant_id) !== e.id) begin
      errors++;
      $display("FAIL grant_id: got %0d required %0d", grant_id, e.id);
    end
    checks++;
    if (rsp_data !== e.data) begin
      errors++;
      $display("FAIL rsp_data id=%0d: got %b required %b", e.id, rsp_data, e.data);
    end
    checks++;
    if (rsp_corrected !== e.corr) begin
      errors++;
      $display("FAIL rsp_corrected id=%0d: got %b required %b", e.id, rsp_corrected, e.corr);
    end
    checks++;
    if (rsp_timeout !== e.tout) begin
      errors++;
      $display("FAIL rsp_timeout id=%0d: got %b required %b", e.id, rsp_timeout, e.tout);
    end
    if (exp_lat > 0) begin
      checks++;
      if (n !== exp_lat) begin
        errors++;
        $display("FAIL latency id=%0d: got %0d cycles required %0d", e.id, n, exp_lat);
      end
    end
    // Other requesters' rsp_ready must not complete the delivery.
    rsp_ready = ~(N'(1) << e.id);
    step();
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== (N'(1) << e.id) || rsp_data !== e.data) begin
      errors++;
      $display("FAIL foreign_ready: rsp_valid=%b rsp_data=%b required %b %b", rsp_valid,
               rsp_data, N'(1) << e.id, e.data);
    end
    if (late) begin
      inject_data = ~e.data;
      inject      = 1'b1;
      step();
      step();
      checks++;
      if (rsp_valid !== (N'(1) << e.id) || rsp_data !== e.data) begin
        errors++;
        $display("FAIL stale_beat: rsp_valid=%b rsp_data=%b required %b %b", rsp_valid,
                 rsp_data, N'(1) << e.id, e.data);
      end
    end
    rsp_ready[e.id] = 1'b1;
    step();
    rsp_ready = '0;
    if (e.corr && exp_err[e.id] < 255) exp_err[e.id]++;
    checks++;
    if (err_count[8*e.id +: 8] !== 8'(exp_err[e.id])) begin
      errors++;
      $display("FAIL err_count[%0d]: got %0d required %0d", e.id, err_count[8*e.id +: 8],
               exp_err[e.id]);
    end
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL rsp_release: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    step();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || edu_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: req_ready=%b rsp_valid=%b edu_in_valid=%b required 0",
               req_ready, rsp_valid, edu_in_valid);
    end
    checks++;
    if (edu_out_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_edu_out_ready: got %b required 0", edu_out_ready);
    end
    checks++;
    if (grant_id !== 2'd0 || err_count !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_state: grant_id=%0d err_count=%h rsp_data=%b required 0", grant_id,
               err_count, rsp_data);
    end
    req_valid = '0;
    rst       = 1'b0;
    #1;
    checks++;
    if (edu_out_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_edu_out_ready: got %b required 1", edu_out_ready);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL idle_no_req: req_ready=%b required 0", req_ready);
    end
    for (int i = 0; i < N; i++) exp_err[i] = 0;
  endtask

  task automatic test_clean();
    txn(0, 7'b0000000, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_single_err();
    txn(2, 7'b0000100, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_data[7*i +: 7] = 7'(1 << i);
    req_valid = '1;
    for (int k = 0; k < 5; k++) txn(k % N, 7'(1 << (k % N)), 1'b1, 3, 1'b0, 1'b1);
    req_valid = '0;
  endtask

  task automatic test_timeout();
    txn(1, 7'b1010101, 1'b0, TO + 2, 1'b1, 1'b0);
    txn(1, 7'b1010111, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    edu_on             = 1'b0;
    req_valid[2]       = 1'b1;
    req_data[14 +: 7]  = 7'b1100110;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rst_wait_accept: req_ready=%b required 0100", req_ready);
    end
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== '0 || {rsp_data, rsp_corrected, rsp_timeout} !== 9'd0) begin
      errors++;
      $display("FAIL rst_wait_outputs: req_ready=%b rsp_valid=%b rsp_data=%b required 0",
               req_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (edu_in_valid !== 1'b0 || edu_out_ready !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_wait_edu: edu_in_valid=%b edu_out_ready=%b grant_id=%0d required 0",
               edu_in_valid, edu_out_ready, grant_id);
    end
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL rst_wait_err_count: got %h required 0", err_count);
    end
    step();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) exp_err[i] = 0;
    inject_data = 7'b1111111;
    inject      = 1'b1;
    step();
    step();
    checks++;
    if (rsp_valid !== '0 || edu_in_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rst_stale_beat: rsp_valid=%b edu_in_valid=%b req_ready=%b required 0",
               rsp_valid, edu_in_valid, req_ready);
    end
    txn(2, 7'b0000000, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 256; k++) txn(3, 7'b0000100, 1'b1, 3, 1'b0, 1'b0);
    checks++;
    if (err_count[24 +: 8] !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: err_count[3]=%0d required 255", err_count[24 +: 8]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    rsp_ready    = '0;
    edu_in_ready = 1'b1;
    test_reset();
    test_clean();
    test_single_err();
    test_round_robin();
    test_timeout();
    test_reset_in_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edu_arb.md
EDU_ARB -- requirements
Module: edu_arb

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing one EDU (2..8).
REQ-002 Parameter TIMEOUT, default 16, is the maximum cycles to wait for an EDU response (>=2).
REQ-003 Parameter IDW, default $clog2(N_REQ), is the width of the requester index.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  N_REQ  per-requester codeword-valid.
REQ-007 req_data  in  7*N_REQ  per-requester 7-bit Hamming(7,4) codeword; requester i occupies bits [7i+6:7i].
REQ-008 req_ready  out  N_REQ  per-requester accept strobe.
REQ-009 rsp_valid  out  N_REQ  per-requester result-valid.
REQ-010 rsp_data  out  7  corrected codeword, shared by all requesters.
REQ-011 rsp_corrected  out  1  result differs from the submitted codeword.
REQ-012 rsp_timeout  out  1  EDU did not answer; rsp_data is the raw input.
REQ-013 rsp_ready  in  N_REQ  per-requester result-accept.
REQ-014 edu_in_valid / edu_in_data[6:0] (out), edu_in_ready (in): codeword channel to the EDU.
REQ-015 edu_out_valid / edu_out_data[6:0] (in), edu_out_ready (out): result channel from the EDU.
REQ-016 grant_id  out  IDW  index of the requester currently being served.
REQ-017 err_count  out  8*N_REQ  per-requester saturating corrected-error counters.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER; only one transaction is outstanding at a time.
REQ-019 IDLE behaviour when any req_valid is high:
- grant the first requester at or after rr_ptr, searching upward with wrap-around;
- assert that requester's req_ready for exactly that cycle;
- capture its data into raw_q and its index into grant_id;
- go to ISSUE.
REQ-020 In IDLE with no req_valid, req_ready SHALL be all-zero and the state SHALL hold.
REQ-021 ISSUE SHALL drive edu_in_valid=1 and edu_in_data=raw_q; on edu_in_ready=1 it clears the timer and goes to WAIT; edu_in_data holds stable while stalled.
REQ-022 WAIT SHALL drive edu_out_ready=1; on edu_out_valid it captures edu_out_data into res_q, sets corrected=(res_q!=raw_q) and timeout=0, and goes to DELIVER.
REQ-023 WAIT timer behaviour:
- the timer increments each WAIT cycle without edu_out_valid;
- when the timer reaches TIMEOUT-1 without a response, set res_q=raw_q, timeout=1 and corrected=0, and go to DELIVER;
- if edu_out_valid arrives in that same cycle, the response wins.
REQ-024 DELIVER SHALL drive rsp_valid[grant_id]=1 only, with rsp_data=res_q and the flags held stable.
- On rsp_ready[grant_id]=1: rr_ptr = (grant_id+1) mod N_REQ, then go to IDLE.
- rsp_ready of non-granted requesters is ignored.
REQ-025 Outside WAIT, edu_out_ready SHALL be 1 and any edu_out_valid beat SHALL be discarded (stale response after a timeout).
REQ-026 Minimum latency SHALL be as follows, assuming edu_in_ready=1 and a one-cycle EDU:
- accept in cycle 0;
- edu_in handshake in cycle 1;
- response in cycle 2;
- rsp_valid from cycle 3.
REQ-027 err_count[i] SHALL increment by 1 on the DELIVER handshake when grant_id=i and rsp_corrected=1, and saturate at 255.
REQ-028 rsp_data, rsp_corrected and rsp_timeout SHALL be 0 whenever the state is not DELIVER.
REQ-029 req_valid dropping while not granted SHALL have no effect; arbitration is re-evaluated every IDLE cycle.

Reset
REQ-030 Asserting rst at any time SHALL immediately force the following:
- state IDLE, rr_ptr=0, grant_id=0, timer=0;
- raw_q=0, res_q=0;
- all err_count=0;
- all req_ready, rsp_valid and edu_in_valid = 0.
REQ-031 While rst is high, edu_out_ready SHALL be 0; after deassertion it follows REQ-025.
REQ-032 A transaction in flight when rst asserts SHALL be abandoned, and a later EDU beat for it SHALL be discarded per REQ-025.

Verification
REQ-033 Clean codeword: requester 0 sends 7'b0000000 and the EDU returns 7'b0000000 -> rsp_valid[0] in cycle 3, rsp_corrected=0, err_count[0]=0.
REQ-034 Single-bit error: requester 2 sends 7'b0000100 and the EDU returns 7'b0000000 -> rsp_corrected=1, err_count[2]=1 after the handshake.
REQ-035 Round-robin: all four requesters are held valid continuously -> grant order 0,1,2,3,0; no requester is granted twice before the others.
REQ-036 Timeout: the EDU never asserts edu_out_valid and requester 1 sends 7'b1010101 -> DELIVER after TIMEOUT WAIT cycles, rsp_data=7'b1010101, rsp_timeout=1; a late EDU beat is dropped.
REQ-037 Counter and reset: 256 corrected results on requester 3 -> err_count[3]=255; asserting rst during WAIT -> all outputs 0 in the same cycle and err_count cleared.
